// File: rtl/calc_responder_if.sv
// calc_responder_if
//   Bundles the request and response banks for calc_responder.
//   Each bank has one lane per port.
//
//   input_packet[p]  : {command[1:0], data1[WIDTH-1:0], data2[WIDTH-1:0]}
//   output_packet[p] : {response[1:0], data[WIDTH-1:0]}
//
//   modport master : initiator side (drives input_packet, observes output_packet)
//   modport slave  : responder side (observes input_packet, drives output_packet)
interface calc_responder_if #(
  parameter int WIDTH = 32
);
  logic [3:0][2*WIDTH+1:0] input_packet;
  logic [3:0][WIDTH+1:0]   output_packet;

  modport master (
    output input_packet,
    input  output_packet
  );

  modport slave (
    input  input_packet,
    output output_packet
  );
endinterface

// File: rtl/calc_responder.sv
// calc_responder
//   Four-port arithmetic responder. Each port latches one non-NOP command and
//   waits for a round-robin grant. Granted operands enter stage 1 of a shared
//   pipeline. Stage 2 computes the result and writes it back to the originating
//   port together with a one-cycle response pulse.
//
//   Ports:
//     clock : rising-edge clock
//     reset : asynchronous, active-low reset
//     bus   : calc_responder_if.slave (input_packet / output_packet banks)
//
//   Commands : 0 NOP, 1 ADD, 2 SUB, 3 SHL (only when CALC_SHIFT_EN is defined)
//   Responses: 0 NO_RESPONSE, 1 SUCCESS, 2 OVERFLOW, 3 INVALID
//
//   Build option:
//     CALC_SHIFT_EN defined   -> command 3 is a logical left shift, and
//                                OVERFLOW is reported if any 1 bit is lost.
//     CALC_SHIFT_EN undefined -> command 3 returns INVALID with data 0.
module calc_responder #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 32
) (
  input logic            clock,
  input logic            reset,
  calc_responder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_BUSY
  } port_state_t;

  localparam logic [1:0] CMD_NOP = 2'd0;
  localparam logic [1:0] CMD_ADD = 2'd1;
  localparam logic [1:0] CMD_SUB = 2'd2;
`ifdef CALC_SHIFT_EN
  localparam logic [1:0] CMD_SHL = 2'd3;
`endif

  localparam logic [1:0] RSP_NONE     = 2'd0;
  localparam logic [1:0] RSP_SUCCESS  = 2'd1;
  localparam logic [1:0] RSP_OVERFLOW = 2'd2;
  localparam logic [1:0] RSP_INVALID  = 2'd3;

  port_state_t      state    [NUM_PORTS];
  logic [1:0]       req_cmd  [NUM_PORTS];
  logic [WIDTH-1:0] req_d1   [NUM_PORTS];
  logic [WIDTH-1:0] req_d2   [NUM_PORTS];
  logic [WIDTH-1:0] out_data [NUM_PORTS];
  logic [1:0]       out_rsp  [NUM_PORTS];

  logic [1:0]       rr_ptr;

  logic             s1_valid;
  logic [1:0]       s1_port;
  logic [1:0]       s1_cmd;
  logic [WIDTH-1:0] s1_d1;
  logic [WIDTH-1:0] s1_d2;

  logic             grant_valid;
  logic [1:0]       grant_port;
  logic [1:0]       cand;

  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] res_data;
  logic [1:0]       res_rsp;
`ifdef CALC_SHIFT_EN
  logic [2*WIDTH-1:0] shl_full;
`endif

  // Round-robin search. The loop runs from the farthest offset down to
  // rr_ptr itself, so the nearest PENDING port at or after rr_ptr is the
  // last one written and therefore wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = rr_ptr;
    cand        = rr_ptr;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = rr_ptr + 2'(i);
      if (state[cand] == ST_PENDING) begin
        grant_valid = 1'b1;
        grant_port  = cand;
      end
    end
  end

  // Stage 2 datapath. The extra result bit catches the ADD carry.
  // The double-width shift catches any bits shifted out by SHL.
  always_comb begin
    add_full = {1'b0, s1_d1} + {1'b0, s1_d2};
`ifdef CALC_SHIFT_EN
    shl_full = {{WIDTH{1'b0}}, s1_d1} << s1_d2[$clog2(WIDTH)-1:0];
`endif
    res_data = '0;
    res_rsp  = RSP_INVALID;
    case (s1_cmd)
      CMD_ADD: begin
        res_data = add_full[WIDTH-1:0];
        res_rsp  = add_full[WIDTH] ? RSP_OVERFLOW : RSP_SUCCESS;
      end
      CMD_SUB: begin
        res_data = s1_d1 - s1_d2;
        res_rsp  = (s1_d2 > s1_d1) ? RSP_OVERFLOW : RSP_SUCCESS;
      end
`ifdef CALC_SHIFT_EN
      CMD_SHL: begin
        res_data = shl_full[WIDTH-1:0];
        res_rsp  = (|shl_full[2*WIDTH-1:WIDTH]) ? RSP_OVERFLOW : RSP_SUCCESS;
      end
`endif
      default: begin
        res_data = '0;
        res_rsp  = RSP_INVALID;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state[p]    <= ST_IDLE;
        req_cmd[p]  <= CMD_NOP;
        req_d1[p]   <= '0;
        req_d2[p]   <= '0;
        out_data[p] <= '0;
        out_rsp[p]  <= RSP_NONE;
      end
      rr_ptr   <= 2'd0;
      s1_valid <= 1'b0;
      s1_port  <= 2'd0;
      s1_cmd   <= CMD_NOP;
      s1_d1    <= '0;
      s1_d2    <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_rsp[p] <= RSP_NONE;
        case (state[p])
          ST_IDLE: begin
            if (bus.input_packet[p][2*WIDTH+1 -: 2] != CMD_NOP) begin
              req_cmd[p] <= bus.input_packet[p][2*WIDTH+1 -: 2];
              req_d1[p]  <= bus.input_packet[p][2*WIDTH-1 -: WIDTH];
              req_d2[p]  <= bus.input_packet[p][WIDTH-1:0];
              state[p]   <= ST_PENDING;
            end
          end
          ST_PENDING: begin
            if (grant_valid && grant_port == 2'(p)) state[p] <= ST_BUSY;
          end
          ST_BUSY: begin
            if (s1_valid && s1_port == 2'(p)) state[p] <= ST_IDLE;
          end
          default: state[p] <= ST_IDLE;
        endcase
      end

      // This assignment comes after the per-port pulse clear, so it takes
      // precedence over that clear.
      if (s1_valid) begin
        out_data[s1_port] <= res_data;
        out_rsp[s1_port]  <= res_rsp;
      end

      s1_valid <= grant_valid;
      if (grant_valid) begin
        s1_port <= grant_port;
        s1_cmd  <= req_cmd[grant_port];
        s1_d1   <= req_d1[grant_port];
        s1_d2   <= req_d2[grant_port];
        rr_ptr  <= grant_port + 2'd1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      bus.output_packet[p] = {out_rsp[p], out_data[p]};
    end
  end

endmodule

// File: tb/tb_calc_responder.sv
// tb_calc_responder
//   Self-checking bench for calc_responder. It runs directed vectors from a
//   table, hand-written multi-cycle sequences, and randomized traffic. A
//   transaction-level model tracks the expected output_packet of every port,
//   and every port is compared after every clock edge.
module tb_calc_responder;

  typedef logic [3:0][65:0] pk_t;

  typedef struct {
    string       name;
    int          port;
    logic [1:0]  cmd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] exp_data;
    logic [1:0]  exp_rsp;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  calc_responder_if #(.WIDTH(32)) bus ();

  calc_responder #(.NUM_PORTS(4), .WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit expired");
    $fatal(1, "[TB] timeout");
  end

  // Reference model state: one outstanding request per port.
  bit          m_has     [4];
  bit          m_granted [4];
  logic [1:0]  m_cmd     [4];
  logic [31:0] m_d1      [4];
  logic [31:0] m_d2      [4];
  logic [31:0] m_exp_data[4];
  logic [1:0]  m_exp_rsp [4];
  int          m_ptr;
  bit          m_fly_valid;
  int          m_fly_port;

  function automatic logic [33:0] model_result(input logic [1:0] cmd,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    longint unsigned wide;
    logic [31:0] d;
    logic [1:0]  r;
    wide = 0;
    d    = 32'h0;
    r    = 2'd3;
    case (cmd)
      2'd1: begin
        wide = 64'(a) + 64'(b);
        d    = wide[31:0];
        r    = (wide > 64'h0000_0000_FFFF_FFFF) ? 2'd2 : 2'd1;
      end
      2'd2: begin
        d = a - b;
        r = (b > a) ? 2'd2 : 2'd1;
      end
      default: begin
`ifdef CALC_SHIFT_EN
        wide = 64'(a) << (b % 32);
        d    = wide[31:0];
        r    = ((wide >> 32) != 0) ? 2'd2 : 2'd1;
`else
        d = 32'h0;
        r = 2'd3;
`endif
      end
    endcase
    return {r, d};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      m_has[p]      = 0;
      m_granted[p]  = 0;
      m_cmd[p]      = 2'd0;
      m_d1[p]       = 32'h0;
      m_d2[p]       = 32'h0;
      m_exp_data[p] = 32'h0;
      m_exp_rsp[p]  = 2'd0;
    end
    m_ptr       = 0;
    m_fly_valid = 0;
    m_fly_port  = 0;
  endtask

  // One clock edge of the model.
  // Grants and accepts are both decided from the state before the edge.
  task automatic model_edge(input pk_t pk);
    bit pre [4];
    int g;
    logic [33:0] r;
    for (int p = 0; p < 4; p++) pre[p] = m_has[p];
    g = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && m_has[(m_ptr + k) % 4] && !m_granted[(m_ptr + k) % 4])
        g = (m_ptr + k) % 4;
    end
    for (int p = 0; p < 4; p++) m_exp_rsp[p] = 2'd0;
    if (m_fly_valid) begin
      r = model_result(m_cmd[m_fly_port], m_d1[m_fly_port], m_d2[m_fly_port]);
      m_exp_rsp[m_fly_port]  = r[33:32];
      m_exp_data[m_fly_port] = r[31:0];
      m_has[m_fly_port]      = 0;
      m_granted[m_fly_port]  = 0;
    end
    for (int p = 0; p < 4; p++) begin
      if (!pre[p] && pk[p][65:64] != 2'd0) begin
        m_has[p]     = 1;
        m_granted[p] = 0;
        m_cmd[p]     = pk[p][65:64];
        m_d1[p]      = pk[p][63:32];
        m_d2[p]      = pk[p][31:0];
      end
    end
    if (g >= 0) begin
      m_granted[g] = 1;
      m_fly_valid  = 1;
      m_fly_port   = g;
      m_ptr        = (g + 1) % 4;
    end else begin
      m_fly_valid = 0;
    end
  endtask

  task automatic check_port(input string name, input int p, input logic [33:0] want);
    checks++;
    if (bus.output_packet[p] !== want) begin
      failures++;
      $display("[TB] FAIL %s port=%0d got=%h want=%h", name, p, bus.output_packet[p], want);
    end
  endtask

  task automatic check_output();
    for (int p = 0; p < 4; p++) check_port("model", p, {m_exp_rsp[p], m_exp_data[p]});
  endtask

  task automatic apply_stimulus(input pk_t pk);
    bus.input_packet = pk;
    @(posedge clock);
    model_edge(pk);
    #1;
    check_output();
  endtask

  function automatic pk_t make_pk(input int port, input logic [1:0] cmd,
                                  input logic [31:0] d1, input logic [31:0] d2);
    pk_t pk;
    pk = '0;
    pk[port] = {cmd, d1, d2};
    return pk;
  endfunction

  vec_t vecs [7];
  pk_t  nop_pk;
  pk_t  all_pk;
  logic [31:0] corners [5];

  initial begin
    int order [4];
    logic [33:0] want;
    pk_t rpk;
    logic [1:0] c;
    logic [31:0] a, b;
    int r;

    checks   = 0;
    failures = 0;
    nop_pk   = '0;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;

    vecs[0] = '{"add_basic",   0, 2'd1, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 2'd1};
    vecs[1] = '{"add_carry",   2, 2'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 2'd2};
    vecs[2] = '{"sub_borrow",  3, 2'd2, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 2'd2};
`ifdef CALC_SHIFT_EN
    vecs[3] = '{"cmd3",        1, 2'd3, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 2'd2};
`else
    vecs[3] = '{"cmd3",        1, 2'd3, 32'h8000_0001, 32'h0000_0001, 32'h0000_0000, 2'd3};
`endif
    vecs[4] = '{"sub_basic",   1, 2'd2, 32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 2'd1};
    vecs[5] = '{"add_nocarry", 0, 2'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 2'd1};
    vecs[6] = '{"sub_equal",   2, 2'd2, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 2'd1};

    // Power-on reset
    reset = 1'b0;
    bus.input_packet = nop_pk;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    for (int p = 0; p < 4; p++) check_port("reset_state", p, 34'h0);
    @(negedge clock);
    reset = 1'b1;

    // Directed single-port vectors: accept at N, pulse at N+2, clear at N+3
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(make_pk(vecs[i].port, vecs[i].cmd, vecs[i].d1, vecs[i].d2));
      apply_stimulus(nop_pk);
      apply_stimulus(nop_pk);
      check_port(vecs[i].name, vecs[i].port, {vecs[i].exp_rsp, vecs[i].exp_data});
      apply_stimulus(nop_pk);
      check_port({vecs[i].name, "_hold"}, vecs[i].port, {2'd0, vecs[i].exp_data});
    end

    // Reset while port 1 is BUSY: nothing may come out afterwards
    apply_stimulus(make_pk(1, 2'd1, 32'h0000_0100, 32'h0000_0200));
    apply_stimulus(nop_pk);
    #2;
    reset = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) check_port("reset_async", p, 34'h0);
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int s = 0; s < 4; s++) begin
      apply_stimulus(nop_pk);
      check_port("no_late_rsp", 1, 34'h0);
    end

    // Four simultaneous requests, rr_ptr = 0 -> order 0,1,2,3
    for (int p = 0; p < 4; p++) all_pk[p] = {2'd2, 32'h0000_0010, 32'h0000_0001};
    order = '{0, 1, 2, 3};
    apply_stimulus(all_pk);
    for (int s = 1; s <= 5; s++) begin
      apply_stimulus(nop_pk);
      for (int p = 0; p < 4; p++) begin
        want = (s >= 2 && order[s-2] == p) ? {2'd1, 32'h0000_000F}
                                           : {2'd0, bus.output_packet[p][31:0]};
        if (s >= 2 && order[s-2] == p) check_port("rr_first", p, want);
        else begin
          checks++;
          if (bus.output_packet[p][33:32] !== 2'd0) begin
            failures++;
            $display("[TB] FAIL rr_first_quiet port=%0d got=%0d want=0", p, bus.output_packet[p][33:32]);
          end
        end
      end
    end

    // Port 1 alone moves rr_ptr to 2, then four again -> order 2,3,0,1
    apply_stimulus(make_pk(1, 2'd1, 32'h0000_0001, 32'h0000_0002));
    repeat (3) apply_stimulus(nop_pk);
    order = '{2, 3, 0, 1};
    apply_stimulus(all_pk);
    for (int s = 1; s <= 5; s++) begin
      apply_stimulus(nop_pk);
      for (int p = 0; p < 4; p++) begin
        checks++;
        want = (s >= 2 && order[s-2] == p) ? {2'd1, 32'h0000_000F} : 34'h0;
        if (bus.output_packet[p][33:32] !== want[33:32] ||
            (want[33:32] != 2'd0 && bus.output_packet[p][31:0] !== want[31:0])) begin
          failures++;
          $display("[TB] FAIL rr_second port=%0d step=%0d got=%h want=%h", p, s, bus.output_packet[p], want);
        end
      end
    end

    // Port 0 holds ADD 1+1 -> pulses at N+2, N+5, N+8, then NOP stops them
    for (int s = 0; s <= 12; s++) begin
      apply_stimulus(s <= 8 ? make_pk(0, 2'd1, 32'h1, 32'h1) : nop_pk);
      checks++;
      if (bus.output_packet[0][33:32] !== ((s == 2 || s == 5 || s == 8) ? 2'd1 : 2'd0)) begin
        failures++;
        $display("[TB] FAIL hold_add step=%0d got=%0d want=%0d", s, bus.output_packet[0][33:32],
                 (s == 2 || s == 5 || s == 8) ? 1 : 0);
      end
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 4; p++) begin
        r = $urandom_range(0, 9);
        c = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
        b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
        if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
        rpk[p] = {c, a, b};
      end
      apply_stimulus(rpk);
    end
    repeat (8) apply_stimulus(nop_pk);

    $display("[TB] done");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_responder.md
# calc_responder

Four-port arithmetic responder that serves command packets from up to four independent initiators and returns one result packet per accepted command. Each port latches a non-NOP request, a round-robin arbiter feeds one request per cycle into a shared two-stage compute pipeline, and the result is written back to the originating port with a one-cycle response pulse. It is the ALU-side endpoint of the input_packet/output_packet bank protocol driven by the unit-level benches.

## Interface
- NUM_PORTS, 4, number of request/response banks (fixed at 4 for this revision)
- WIDTH, 32, operand and result width
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- input_packet  input  [3:0] x 66  per port: command[65:64], data1[63:32], data2[31:0]
- output_packet  output  [3:0] x 34  per port: response[33:32], data[31:0]
- Command encoding: 0 NOP, 1 ADD, 2 SUB, 3 SHL/reserved
- Response encoding: 0 NO_RESPONSE, 1 SUCCESS, 2 OVERFLOW, 3 INVALID

## Operation
- Per-port FSM: IDLE -> PENDING -> BUSY -> IDLE.
- IDLE: on a rising edge with command != NOP, latch command/data1/data2 and go to PENDING. NOP leaves the port in IDLE.
- PENDING: wait for the grant. Inputs are ignored.
- Arbiter: one grant per cycle to the first PENDING port at or after rr_ptr, searching upward with wrap 3->0. On a grant, the port goes to BUSY, operands load pipe stage 1, and rr_ptr <= granted+1 mod 4. With no PENDING port, rr_ptr is held.
- Stage 2 computes and writes output_packet[p].data/response, and port p returns to IDLE.
- ADD: data = (data1+data2)[31:0]. Carry-out -> OVERFLOW, else SUCCESS.
- SUB: data = (data1-data2)[31:0]. Borrow (data2 > data1) -> OVERFLOW, else SUCCESS.
- Command 3: see Configuration.
- response is non-zero for exactly one cycle, then returns to NO_RESPONSE.
- data holds its last value until the next result for that port.

## Timing
- Reset (async assert, sync-safe deassert):
  - all ports IDLE, pipeline invalid, rr_ptr = 0
  - every output_packet[p].data = 0, response = NO_RESPONSE
  - in-flight requests are discarded and produce no response
- Uncontended latency: accept at edge N, grant at N+1, response visible N+2 to N+3.
- Contended: each additional port granted ahead of a request adds one cycle. Worst case, four simultaneous requests: responses at N+2..N+5.
- Re-accept: a port returning IDLE at edge N+2 may accept a new non-NOP command at N+3. The initiator holding the same command re-issues it; the initiator drives NOP to stop.
- Simultaneous events on one port in one cycle, response clear plus new accept: both occur and are independent.
- Simultaneous accepts on several ports are all latched in the same cycle. Arbitration order follows rr_ptr.
- Throughput: one result per cycle across all ports. No back-pressure on outputs.

## Configuration
- CALC_SHIFT_EN defined: command 3 = SHL.
  - data = data1 << data2[4:0]
  - OVERFLOW if any 1-bit is shifted out, else SUCCESS
- CALC_SHIFT_EN undefined: command 3 is reserved.
  - response = INVALID, data = 0
  - latency and arbitration are identical to other commands

## Test plan
- Reset: assert reset low mid-stream with port 1 BUSY -> all data = 0x00000000, all responses NO_RESPONSE, and no late response from port 1 after release.
- Port 0 ADD, 0x00000003 + 0x00000004, accepted at edge N -> data 0x00000007, SUCCESS during cycle N+2 only, NO_RESPONSE at N+3, data held at 0x7.
- Port 2 ADD, 0xFFFFFFFF + 0x00000001 -> data 0x00000000, OVERFLOW. Port 3 SUB, 0x00000005 - 0x00000007 -> data 0xFFFFFFFE, OVERFLOW.
- All four ports issue SUB 0x10 - 0x01 at the same edge N, rr_ptr = 0 -> responses from ports 0, 1, 2, 3 at N+2, N+3, N+4, N+5, each data 0x0000000F. Repeating after rr_ptr = 2 gives order 2, 3, 0, 1.
- Port 1 command 3, data1 0x80000001, data2 0x00000001:
  - with CALC_SHIFT_EN -> data 0x00000002, OVERFLOW
  - without -> data 0x00000000, INVALID
- Port 0 holds ADD 1+1 continuously -> SUCCESS pulses every 3 cycles (N+2, N+5, ...). Switching to NOP stops further responses.
